// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - frame sequencer between UART receiver and byte buffer
//
// Purpose: turns rx_done_tick pulses into buffer write strobes, closes a frame
// on buffer full (count == DEPTH) or on TERM_CHAR, presents frame_valid/frame_len
// until frame_ack, then issues a one-cycle buffer clear strobe and waits for
// the buffer to report empty before accepting the next frame.
// Optional: define FRAME_TIMEOUT_EN to also close a partial frame after
// TIMEOUT_CYCLES idle cycles in COLLECT.
//
// Ports:
//   clk_100Mhz    in   system clock
//   reset         in   asynchronous, active-high
//   rx_done_tick  in   one-cycle pulse, rx_data valid
//   rx_data       in   received byte
//   fifo_full     in   buffer full flag
//   fifo_empty    in   buffer empty flag
//   fifo_wr       out  buffer write strobe
//   fifo_wr_data  out  buffer write data
//   fifo_rd       out  buffer clear strobe
//   frame_valid   out  frame complete, buffer contents stable
//   frame_len     out  valid bytes in frame, 1..DEPTH
//   frame_ack     in   consumer has taken the frame
//   overrun       out  one-cycle pulse: received byte dropped
module uart_frame_ctrl #(
  parameter int                   DATA_SIZE      = 8,
  parameter int                   DEPTH_EXP      = 3,
  parameter logic [DATA_SIZE-1:0] TERM_CHAR      = 'h0D,
  parameter int                   TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk_100Mhz,
  input  logic                 reset,
  input  logic                 rx_done_tick,
  input  logic [DATA_SIZE-1:0] rx_data,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  output logic                 fifo_wr,
  output logic [DATA_SIZE-1:0] fifo_wr_data,
  output logic                 fifo_rd,
  output logic                 frame_valid,
  output logic [DEPTH_EXP:0]   frame_len,
  input  logic                 frame_ack,
  output logic                 overrun
);

  localparam logic [DEPTH_EXP:0] DEPTH_CNT = (DEPTH_EXP+1)'(1) << DEPTH_EXP;

  typedef enum logic [1:0] {IDLE, COLLECT, READY, CLEAR} state_t;

  state_t                 state_q;
  logic [DEPTH_EXP:0]     count_q;
  logic [DEPTH_EXP:0]     count_d;
  logic                   fifo_wr_q;
  logic [DATA_SIZE-1:0]   fifo_wr_data_q;
  logic                   fifo_rd_q;
  logic                   frame_valid_q;
  logic [DEPTH_EXP:0]     frame_len_q;
  logic                   overrun_q;
  logic                   is_term;
  logic                   accept;
  logic                   drop;

`ifdef FRAME_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q;
  logic              timeout;
  // READY is entered one edge early so that the registered frame_valid
  // rises exactly TIMEOUT_CYCLES edges after the last accepted byte.
  assign timeout = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 2));
`endif

  always_comb begin
    is_term = 1'b0;
    accept  = 1'b0;
    drop    = 1'b0;
    count_d = count_q + (DEPTH_EXP+1)'(1);
    if (rx_data == TERM_CHAR) is_term = 1'b1;
    if ((state_q == IDLE) || (state_q == COLLECT)) begin
      accept = rx_done_tick && !is_term && !fifo_full;
      drop   = rx_done_tick && !is_term &&  fifo_full;
    end
  end

  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      fifo_wr_q      <= 1'b0;
      fifo_wr_data_q <= '0;
      fifo_rd_q      <= 1'b0;
      frame_valid_q  <= 1'b0;
      frame_len_q    <= '0;
      overrun_q      <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      idle_q         <= '0;
`endif
    end else begin
      fifo_wr_q <= 1'b0;
      fifo_rd_q <= 1'b0;
      overrun_q <= 1'b0;
      if (accept) begin
        fifo_wr_q      <= 1'b1;
        fifo_wr_data_q <= rx_data;
      end
      if (drop) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (accept) begin
            count_q <= (DEPTH_EXP+1)'(1);
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            count_q <= count_d;
            if (count_d == DEPTH_CNT) state_q <= READY;
          end else if (rx_done_tick && is_term) begin
            state_q <= READY;
`ifdef FRAME_TIMEOUT_EN
          end else if (timeout) begin
            state_q <= READY;
`endif
          end
        end
        READY: begin
          if (rx_done_tick) overrun_q <= 1'b1;
          // Ack only counts once frame_valid has actually been presented.
          if (frame_valid_q && frame_ack) begin
            state_q       <= CLEAR;
            frame_valid_q <= 1'b0;
            fifo_rd_q     <= 1'b1;
          end else begin
            frame_valid_q <= 1'b1;
            frame_len_q   <= count_q;
          end
        end
        CLEAR: begin
          if (rx_done_tick) overrun_q <= 1'b1;
          // The empty flag is only trusted once the clear strobe has retired.
          if (!fifo_rd_q && fifo_empty) begin
            state_q     <= IDLE;
            count_q     <= '0;
            frame_len_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase

`ifdef FRAME_TIMEOUT_EN
      if ((state_q == COLLECT) && !accept && !timeout) idle_q <= idle_q + IDLE_W'(1);
      else                                             idle_q <= '0;
`endif
    end
  end

  assign fifo_wr      = fifo_wr_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign fifo_rd      = fifo_rd_q;
  assign frame_valid  = frame_valid_q;
  assign frame_len    = frame_len_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - self-checking bench for uart_frame_ctrl
module tb_uart_frame_ctrl;

`ifdef FRAME_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 1_000_000;
`endif

  logic       clk_100Mhz = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       fifo_full = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       frame_ack = 1'b0;
  logic       fifo_wr;
  logic [7:0] fifo_wr_data;
  logic       fifo_rd;
  logic       frame_valid;
  logic [3:0] frame_len;
  logic       overrun;

  int total = 0;
  int bad = 0;

  uart_frame_ctrl #(.DATA_SIZE(8), .DEPTH_EXP(3), .TERM_CHAR(8'h0D), .TIMEOUT_CYCLES(TO)) dut (
    .clk_100Mhz  (clk_100Mhz),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_wr     (fifo_wr),
    .fifo_wr_data(fifo_wr_data),
    .fifo_rd     (fifo_rd),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_ack   (frame_ack),
    .overrun     (overrun)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  typedef struct {
    logic       tick;
    logic [7:0] data;
    logic       full;
    logic       empty;
    logic       ack;
    logic       wr;
    logic [7:0] wdata;
    logic       rd;
    logic       valid;
    logic [3:0] len;
    logic       ovr;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk_100Mhz);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_data = b;
    tick_clk();
    rx_done_tick = 1'b0;
    chk("byte_wr", 32'(fifo_wr), 32'd1);
    chk("byte_wr_data", 32'(fifo_wr_data), 32'(b));
  endtask

  task automatic send_term();
    rx_done_tick = 1'b1;
    rx_data = 8'h0D;
    tick_clk();
    rx_done_tick = 1'b0;
    chk("term_no_wr", 32'(fifo_wr), 32'd0);
    tick_clk();
  endtask

  task automatic finish_frame(input logic [3:0] len);
    chk("frame_valid", 32'(frame_valid), 32'd1);
    chk("frame_len", 32'(frame_len), 32'(len));
    frame_ack = 1'b1;
    tick_clk();
    frame_ack = 1'b0;
    chk("ack_rd", 32'(fifo_rd), 32'd1);
    chk("ack_valid_low", 32'(frame_valid), 32'd0);
    fifo_empty = 1'b1;
    tick_clk();
    chk("rd_one_cycle", 32'(fifo_rd), 32'd0);
    tick_clk();
    chk("idle_len0", 32'(frame_len), 32'd0);
    fifo_empty = 1'b0;
  endtask

  initial begin
    int n;
    //           tick data   full empty ack  wr  wdata  rd valid len ovr
    vecs[0]  = '{1, 8'h31, 0, 1, 0, 1, 8'h31, 0, 0, 0, 0};
    vecs[1]  = '{0, 8'h00, 0, 0, 0, 0, 8'h31, 0, 0, 0, 0};
    vecs[2]  = '{1, 8'h32, 0, 0, 0, 1, 8'h32, 0, 0, 0, 0};
    vecs[3]  = '{1, 8'h33, 0, 0, 0, 1, 8'h33, 0, 0, 0, 0};
    vecs[4]  = '{1, 8'h0D, 0, 0, 0, 0, 8'h33, 0, 0, 0, 0};
    vecs[5]  = '{0, 8'h00, 0, 0, 0, 0, 8'h33, 0, 1, 3, 0};
    vecs[6]  = '{0, 8'h00, 0, 0, 1, 0, 8'h33, 1, 0, 3, 0};
    vecs[7]  = '{0, 8'h00, 0, 0, 0, 0, 8'h33, 0, 0, 3, 0};
    vecs[8]  = '{0, 8'h00, 0, 1, 0, 0, 8'h33, 0, 0, 0, 0};
    vecs[9]  = '{1, 8'h0D, 0, 1, 0, 0, 8'h33, 0, 0, 0, 0};
    vecs[10] = '{1, 8'h55, 1, 1, 0, 0, 8'h33, 0, 0, 0, 1};
    vecs[11] = '{0, 8'h00, 0, 1, 0, 0, 8'h33, 0, 0, 0, 0};
    vecs[12] = '{1, 8'h60, 0, 1, 0, 1, 8'h60, 0, 0, 0, 0};
    vecs[13] = '{1, 8'h0D, 0, 0, 0, 0, 8'h60, 0, 0, 0, 0};
    vecs[14] = '{1, 8'h55, 0, 0, 0, 0, 8'h60, 0, 1, 1, 1};
    vecs[15] = '{1, 8'h56, 0, 0, 1, 0, 8'h60, 1, 0, 1, 1};
    vecs[16] = '{1, 8'h57, 0, 1, 0, 0, 8'h60, 0, 0, 1, 1};
    vecs[17] = '{0, 8'h00, 0, 1, 0, 0, 8'h60, 0, 0, 0, 0};
    vecs[18] = '{0, 8'h00, 0, 1, 1, 0, 8'h60, 0, 0, 0, 0};

    tick_clk();
    tick_clk();
    chk("rst_wr", 32'(fifo_wr), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_len", 32'(frame_len), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick_clk();

    for (int i = 0; i < 19; i++) begin
      rx_done_tick = vecs[i].tick;
      rx_data      = vecs[i].data;
      fifo_full    = vecs[i].full;
      fifo_empty   = vecs[i].empty;
      frame_ack    = vecs[i].ack;
      tick_clk();
      chk($sformatf("v%0d_wr", i), 32'(fifo_wr), 32'(vecs[i].wr));
      chk($sformatf("v%0d_wdata", i), 32'(fifo_wr_data), 32'(vecs[i].wdata));
      chk($sformatf("v%0d_rd", i), 32'(fifo_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_valid", i), 32'(frame_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_len", i), 32'(frame_len), 32'(vecs[i].len));
      chk($sformatf("v%0d_ovr", i), 32'(overrun), 32'(vecs[i].ovr));
    end
    rx_done_tick = 1'b0;
    frame_ack = 1'b0;
    fifo_full = 1'b0;
    fifo_empty = 1'b0;

    // Full 8-byte frame, spaced 100 cycles apart.
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h41 + 8'(i));
      tick_clk();
      chk("full_wr_single", 32'(fifo_wr), 32'd0);
      chk("full_valid", 32'(frame_valid), (i == 7) ? 32'd1 : 32'd0);
      if (i == 7) chk("full_len", 32'(frame_len), 32'd8);
      else repeat (98) tick_clk();
    end
    rx_done_tick = 1'b1;
    rx_data = 8'h55;
    tick_clk();
    rx_done_tick = 1'b0;
    chk("ready_ovr", 32'(overrun), 32'd1);
    chk("ready_no_wr", 32'(fifo_wr), 32'd0);
    tick_clk();
    chk("ready_ovr_pulse", 32'(overrun), 32'd0);
    frame_ack = 1'b1;
    tick_clk();
    frame_ack = 1'b0;
    chk("full_ack_rd", 32'(fifo_rd), 32'd1);
    chk("full_ack_valid", 32'(frame_valid), 32'd0);
    rx_done_tick = 1'b1;
    rx_data = 8'h56;
    tick_clk();
    rx_done_tick = 1'b0;
    chk("clear_ovr", 32'(overrun), 32'd1);
    chk("clear_no_wr", 32'(fifo_wr), 32'd0);
    chk("clear_rd_done", 32'(fifo_rd), 32'd0);
    fifo_empty = 1'b1;
    tick_clk();
    chk("clear_idle_len", 32'(frame_len), 32'd0);
    chk("clear_ovr_pulse", 32'(overrun), 32'd0);
    fifo_empty = 1'b0;
    send_byte(8'h70);
    send_term();
    finish_frame(4'd1);

    // Reset during the 4th write pulse.
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wr", 32'(fifo_wr), 32'd0);
    chk("mid_rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("mid_rst_valid", 32'(frame_valid), 32'd0);
    chk("mid_rst_len", 32'(frame_len), 32'd0);
    tick_clk();
    tick_clk();
    reset = 1'b0;
    tick_clk();
    send_byte(8'h21);
    send_byte(8'h22);
    send_term();
    finish_frame(4'd2);

`ifdef FRAME_TIMEOUT_EN
    send_byte(8'h11);
    send_byte(8'h12);
    n = 0;
    while (!frame_valid && n < 200) begin
      tick_clk();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd50);
    finish_frame(4'd2);
`else
    send_byte(8'h11);
    n = 0;
    repeat (1000) begin
      tick_clk();
      if (frame_valid) n++;
    end
    chk("no_timeout", 32'(n), 32'd0);
    send_term();
    finish_frame(4'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
